alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 48 ++++
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for alu_seq. The BUSY state only exists
// when ALU_SEQ_MUL_EN is defined.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_NOR = 4'd4,
        OP_XOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_SLT = 4'd9,
        OP_MUL = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        ST_BUSY = 2'd1,
`endif
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle for N cycles.
// done is high during the last iteration; p is then the full 2N-bit product.
module alu_mul_iter #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc_next;

    // The final iteration's sum is handed out combinationally so the owner can
    // capture it on the same edge that would have stored it here.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = (cnt == CW'(1));
    assign p        = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(N);
        end else if (cnt != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with a registered result stage and valid/ready handshakes.
// Define ALU_SEQ_MUL_EN to add the iterative MUL; otherwise opcode 10 is reserved.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        A,
    input  logic [N-1:0]        B,
    input  logic [ALU_OP_W-1:0] OP,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        C,
    output logic                OV,
    output logic                CY,
    output logic                Z,
    output logic                ERR,
    output logic [1:0]          dbg_state
);

    state_t         state;
    logic           xfer_in;
    logic [N-1:0]   r_c;
    logic           r_ov;
    logic           r_cy;
    logic           r_err;
    logic [N:0]     sum;
    logic [SHW-1:0] sh;

    // A beat moves on a rising edge where valid and ready are both high; once
    // out_valid rises, C and flags stay frozen until the consumer takes them.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign xfer_in   = in_valid && in_ready;
    assign dbg_state = state;
    assign sh        = B[SHW-1:0];

    always_comb begin
        r_c   = '0;
        r_ov  = 1'b0;
        r_cy  = 1'b0;
        r_err = 1'b0;
        sum   = '0;
        case (OP)
            OP_ADD: begin
                sum  = {1'b0, A} + {1'b0, B};
                r_c  = sum[N-1:0];
                r_cy = sum[N];
                r_ov = (A[N-1] == B[N-1]) && (r_c[N-1] != A[N-1]);
            end
            OP_SUB: begin
                r_c  = A - B;
                r_cy = (A < B);
                r_ov = (A[N-1] != B[N-1]) && (r_c[N-1] != A[N-1]);
            end
            OP_AND:  r_c = A & B;
            OP_OR:   r_c = A | B;
            OP_NOR:  r_c = ~(A | B);
            OP_XOR:  r_c = A ^ B;
            OP_SLL:  r_c = A << sh;
            OP_SRL:  r_c = A >> sh;
            OP_SRA:  r_c = $signed(A) >>> sh;
            // Direct signed compare, immune to A-B overflow.
            OP_SLT:  r_c = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            default: r_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic           mul_start;
    logic           mul_done;
    logic [2*N-1:0] mul_p;

    assign mul_start = xfer_in && (OP == OP_MUL);

    alu_mul_iter #(.N(N)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (A),
        .b     (B),
        .done  (mul_done),
        .p     (mul_p)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            C     <= '0;
            OV    <= 1'b0;
            CY    <= 1'b0;
            Z     <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (xfer_in) begin
`ifdef ALU_SEQ_MUL_EN
                        if (OP == OP_MUL) begin
                            state <= ST_BUSY;
                        end else begin
`else
                        begin
`endif
                            state <= ST_DONE;
                            C     <= r_c;
                            OV    <= r_ov;
                            CY    <= r_cy;
                            Z     <= (r_c == '0);
                            ERR   <= r_err;
                        end
                    end else if (out_valid && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state <= ST_DONE;
                        C     <= mul_p[N-1:0];
                        OV    <= (mul_p[2*N-1:N] != '0);
                        CY    <= 1'b0;
                        Z     <= (mul_p[N-1:0] == '0);
                        ERR   <= 1'b0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at N=8, with a result scoreboard and
// directed latency, back-pressure and reset cases.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int N = 8;
    localparam int W = N + 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   OP;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] C;
    logic         OV;
    logic         CY;
    logic         Z;
    logic         ERR;
    logic [1:0]   dbg_state;

    int           total;
    int           bad;
    logic [W-1:0] exp_q[$];
    logic [1:0]   ready_mode;
    logic         rnd_ready;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .OV        (OV),
        .CY        (CY),
        .Z         (Z),
        .ERR       (ERR),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // out_ready: 0 = held low, 1 = held high, 2 = random each cycle
    assign out_ready = (ready_mode == 2'd2) ? rnd_ready : ready_mode[0];

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        int          sa;
        int          sb;
        int          r;
        int          sh;
        logic [7:0]  c;
        logic        ov;
        logic        cy;
        logic        err;
        logic [15:0] p;
        sa  = $signed(a);
        sb  = $signed(b);
        sh  = int'(b[2:0]);
        c   = 8'h00;
        ov  = 1'b0;
        cy  = 1'b0;
        err = 1'b0;
        r   = 0;
        case (op)
            4'd0: begin
                r  = int'(a) + int'(b);
                c  = r[7:0];
                cy = (r > 255);
                ov = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            4'd1: begin
                r  = int'(a) - int'(b);
                c  = r[7:0];
                cy = (a < b);
                ov = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = ~(a | b);
            4'd5: c = a ^ b;
            4'd6: begin r = int'(a) * (1 << sh); c = r[7:0]; end
            4'd7: begin r = int'(a) / (1 << sh); c = r[7:0]; end
            4'd8: begin r = sa >>> sh; c = r[7:0]; end
            4'd9: c = (sa < sb) ? 8'h01 : 8'h00;
            4'd10: begin
                if (MUL_EN) begin
                    p  = 16'(a) * 16'(b);
                    c  = p[7:0];
                    ov = (p[15:8] != 8'h00);
                end else begin
                    err = 1'b1;
                end
            end
            default: err = 1'b1;
        endcase
        return {c, ov, cy, (c == 8'h00), err};
    endfunction

    // driver: call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output int waits);
        waits    = 0;
        A        = a;
        B        = b;
        OP       = op;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 60) break;
        end
        if (waits > 60) begin
            check("accept_timeout", 64'(waits), 64'd0);
        end else begin
            exp_q.push_back(model(a, b, op));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every cycle with out_valid must show the oldest expected result
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                check("result", {C, OV, CY, Z, ERR}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        OP         = '0;
        ready_mode = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {out_valid, C, OV, CY, Z, ERR}, 64'd0);
        check("rst_state", dbg_state, 64'd0);
        check("rst_in_ready", in_ready, 64'd1);
        rst_n = 1'b1;

        // ADD overflow, accepted on the very first edge after release
        issue(8'h7F, 8'h01, 4'd0, n);
        check("first_accept_wait", n, 0);
        check("add_valid", out_valid, 1);
        check("add_flags", {C, OV, CY, Z, ERR}, {8'h80, 4'b1000});

        issue(8'h00, 8'h01, 4'd1, n);
        check("b2b_accept_wait", n, 0);
        check("sub_flags", {C, OV, CY, Z, ERR}, {8'hFF, 4'b0100});

        issue(8'h80, 8'h7F, 4'd9, n);
        check("slt_c", C, 8'h01);

        issue(8'h10, 8'h10, 4'd10, n);
`ifdef ALU_SEQ_MUL_EN
        for (int i = 1; i <= N; i++) begin
            check("mul_busy_in_ready", in_ready, 0);
            check("mul_busy_out_valid", out_valid, 0);
            tick();
        end
        check("mul_done_valid", out_valid, 1);
        check("mul_flags", {C, OV, CY, Z, ERR}, {8'h00, 4'b1010});
`else
        check("mul_rsv_valid", out_valid, 1);
        check("mul_rsv_flags", {C, OV, CY, Z, ERR}, {8'h00, 4'b0011});
`endif
        tick();

        // back-pressure: result must hold while out_ready is low
        ready_mode = 2'd0;
        issue(8'h03, 8'h04, 4'd0, n);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_c", C, 8'h07);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            tick();
        end
        ready_mode = 2'd1;
        issue(8'h80, 8'h01, 4'd8, n);
        check("bp_release_wait", n, 0);
        check("sra_c", C, 8'hC0);

        issue(8'h12, 8'h34, 4'd13, n);
        check("rsv_flags", {C, OV, CY, Z, ERR}, {8'h00, 4'b0011});

        // reset in the middle of a multiply
        issue(8'h10, 8'h10, 4'd10, n);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {out_valid, C, OV, CY, Z, ERR}, 64'd0);
        check("midrst_state", dbg_state, 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("post_rst_quiet", out_valid, 0);
            tick();
        end

        // random traffic with random back-pressure
        ready_mode = 2'd2;
        for (int i = 0; i < 150; i++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), n);
            repeat ($urandom_range(0, 2)) tick();
        end

        ready_mode = 2'd1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
